// File: rtl/load_store_unit.sv
// Memory-access stage: ALU ops write back after 1 cycle; LDR/STR run one word access on a req/ready port.
// Loads write back the cycle after mem_ready; busy holds upstream in REQ/WB; misalignment and timeout pulse fault.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  type_code,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [3:0]  rd,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, REQ, WB} state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [3:0]         rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wb_valid_q, wb_valid_d;
  logic [3:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               fault_q, fault_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = '0;
    wb_data_d  = '0;
    fault_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (type_code)
            2'b00: begin
              wb_valid_d = 1'b1;
              wb_rd_d    = rd;
              wb_data_d  = alu_result;
            end
            2'b01, 2'b10: begin
              if (alu_result[1:0] != 2'b00) begin
                fault_d = 1'b1;
              end else begin
                addr_d  = {alu_result[31:2], 2'b00};
                wdata_d = store_data;
                we_d    = type_code[1];
                rd_d    = rd;
                cnt_d   = '0;
                state_d = REQ;
              end
            end
            default: ;
          endcase
        end
      end
      REQ: begin
        // A ready arriving on the last allowed cycle still completes normally.
        if (mem_ready) begin
          cnt_d = '0;
          if (we_q) begin
            state_d = IDLE;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = mem_rdata;
            state_d    = WB;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      fault_q    <= fault_d;
    end
  end

  // Memory-side outputs are gated by state so they read zero outside REQ.
  assign busy      = (state_q != IDLE);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = (mem_req && we_q) ? wdata_q : '0;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; writebacks and faults are scoreboarded and popped as the DUT emits them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  type_code;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [3:0]  rd;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;

  int n_assert = 0;
  int n_fail   = 0;

  logic [35:0] wb_q[$];
  int          fault_q[$];

  load_store_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .type_code  (type_code),
    .alu_result (alu_result),
    .store_data (store_data),
    .rd         (rd),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] sd, input logic [3:0] r);
    in_valid   = 1'b1;
    type_code  = t;
    alu_result = a;
    store_data = sd;
    rd         = r;
  endtask

  // Scoreboard consumer: every wb_valid/fault pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wb_valid === 1'b1 && fault === 1'b1)
        check("wb_and_fault", {30'b0, wb_valid, fault}, 32'h2);
      if (wb_valid === 1'b1) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", {31'b0, wb_valid}, 32'h0);
        end else begin
          logic [35:0] e;
          e = wb_q.pop_front();
          check("wb_rd", {28'b0, wb_rd}, {28'b0, e[35:32]});
          check("wb_data", wb_data, e[31:0]);
        end
      end
      if (fault === 1'b1) begin
        if (fault_q.size() == 0) check("fault_unexpected", {31'b0, fault}, 32'h0);
        else void'(fault_q.pop_front());
      end
    end
  end

  initial begin
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; type_code = 2'b00; alu_result = '0;
    store_data = '0; rd = '0; mem_ready = 1'b0; mem_rdata = '0;
    #22;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_mem_req", {31'b0, mem_req}, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wb_valid", {31'b0, wb_valid}, 0);
    check("rst_wb_rd", {28'b0, wb_rd}, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_fault", {31'b0, fault}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ALU pass-through
    issue(2'b00, 32'hFFFF_FFF9, 32'h0, 4'd3);
    wb_q.push_back({4'd3, 32'hFFFF_FFF9});
    tick();
    in_valid = 1'b0;
    check("alu_wb_valid", {31'b0, wb_valid}, 1);
    check("alu_busy", {31'b0, busy}, 0);
    check("alu_mem_req", {31'b0, mem_req}, 0);
    tick();
    check("alu_wb_pulse_end", {31'b0, wb_valid}, 0);

    // Load with 2 wait states; an ALU op presented while busy must be ignored
    issue(2'b01, 32'h0000_0100, 32'h0, 4'd5);
    tick();
    issue(2'b00, 32'h0000_0055, 32'h0, 4'd9);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      check("ld_mem_req", {31'b0, mem_req}, 1);
      check("ld_mem_addr", mem_addr, 32'h100);
      check("ld_mem_we", {31'b0, mem_we}, 0);
      if (busy) cnt++;
      if (i == 2) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        wb_q.push_back({4'd5, 32'hDEAD_BEEF});
      end
      tick();
    end
    in_valid = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    check("ld_wb_valid", {31'b0, wb_valid}, 1);
    check("ld_wb_mem_req", {31'b0, mem_req}, 0);
    check("ld_wb_addr_clr", mem_addr, 0);
    if (busy) cnt++;
    tick();
    check("ld_busy_cycles", cnt, 4);
    check("ld_idle_busy", {31'b0, busy}, 0);

    // Store, immediate ready; ALU op accepted on IDLE re-entry
    issue(2'b10, 32'h0000_0204, 32'h1234_5678, 4'd0);
    tick();
    in_valid = 1'b0;
    check("st_mem_req", {31'b0, mem_req}, 1);
    check("st_mem_we", {31'b0, mem_we}, 1);
    check("st_mem_addr", mem_addr, 32'h204);
    check("st_mem_wdata", mem_wdata, 32'h1234_5678);
    check("st_busy", {31'b0, busy}, 1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("st_done_req", {31'b0, mem_req}, 0);
    check("st_done_busy", {31'b0, busy}, 0);
    check("st_no_wb", {31'b0, wb_valid}, 0);
    check("st_wdata_clr", mem_wdata, 0);
    issue(2'b00, 32'h0000_00A5, 32'h0, 4'd7);
    wb_q.push_back({4'd7, 32'h0000_00A5});
    tick();
    in_valid = 1'b0;
    check("b2b_wb_valid", {31'b0, wb_valid}, 1);

    // Misaligned load
    issue(2'b01, 32'h0000_0103, 32'h0, 4'd1);
    fault_q.push_back(1);
    tick();
    in_valid = 1'b0;
    check("mis_fault", {31'b0, fault}, 1);
    check("mis_mem_req", {31'b0, mem_req}, 0);
    check("mis_busy", {31'b0, busy}, 0);
    tick();
    check("mis_fault_end", {31'b0, fault}, 0);
    check("mis_mem_req2", {31'b0, mem_req}, 0);

    // Timeout with ready held low
    issue(2'b01, 32'h0000_0300, 32'h0, 4'd2);
    fault_q.push_back(1);
    tick();
    in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      cnt++;
      tick();
    end
    check("to_req_cycles", cnt, 16);
    check("to_fault", {31'b0, fault}, 1);
    check("to_busy", {31'b0, busy}, 0);
    tick();
    check("to_fault_end", {31'b0, fault}, 0);

    // Ready on the 16th REQ cycle wins over timeout
    issue(2'b01, 32'h0000_0300, 32'h0, 4'd2);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    check("to16_mem_req", {31'b0, mem_req}, 1);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    wb_q.push_back({4'd2, 32'hCAFE_F00D});
    tick();
    mem_ready = 1'b0;
    check("to16_wb_valid", {31'b0, wb_valid}, 1);
    check("to16_no_fault", {31'b0, fault}, 0);
    tick();

    // Reset during the second REQ cycle of a load
    issue(2'b01, 32'h0000_0400, 32'h0, 4'd6);
    tick();
    in_valid = 1'b0;
    tick();
    check("rr_pre_req", {31'b0, mem_req}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_mem_req", {31'b0, mem_req}, 0);
    check("rr_busy", {31'b0, busy}, 0);
    check("rr_wb_valid", {31'b0, wb_valid}, 0);
    check("rr_fault", {31'b0, fault}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rr_idle_req", {31'b0, mem_req}, 0);
    issue(2'b00, 32'h0000_0077, 32'h0, 4'd4);
    wb_q.push_back({4'd4, 32'h0000_0077});
    tick();
    in_valid = 1'b0;
    check("rr_alu_wb", {31'b0, wb_valid}, 1);
    tick();
    tick();

    check("sb_wb_empty", wb_q.size(), 0);
    check("sb_fault_empty", fault_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
